regfile_access_arbiter: RTL and testbench
=========================================

Name: regfile_access_arbiter

Overview:
- Shares the single-access 32x32 register file between three requesters: pipeline writeback, decode operand read, and debug.
- The register file does one operation per clock: a write when we=1, or a read of two registers when we=0, with read data registered one cycle later.
- This block grants at most one slot per cycle, routes read data back to the requester that issued the read, drops writes to x0, and sequences register-file clearing after reset.

Parameters:
- INIT_CYCLES, 2, number of cycles o_rf_reset stays high after i_reset_n deasserts (minimum 1).
- DBG_MAX_WAIT, 8, number of consecutive cycles debug may be denied before it is promoted to top priority for one grant.

Ports:
- i_clk  in  1  clock; all state on rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_wb_valid  in  1  writeback request.
- i_wb_rd  in  5  writeback destination register.
- i_wb_data  in  32  writeback data.
- o_wb_ready  out  1  writeback accepted this cycle.
- i_dec_valid  in  1  decode read request.
- i_dec_rs1  in  5  decode source register 1.
- i_dec_rs2  in  5  decode source register 2.
- o_dec_ready  out  1  decode read issued this cycle.
- o_dec_rsp_valid  out  1  o_rs1_data and o_rs2_data are valid.
- o_rs1_data  out  32  read data for rs1.
- o_rs2_data  out  32  read data for rs2.
- i_dbg_valid  in  1  debug request.
- i_dbg_we  in  1  debug request is a write (1) or a read (0).
- i_dbg_addr  in  5  debug register address.
- i_dbg_wdata  in  32  debug write data.
- o_dbg_ready  out  1  debug request accepted this cycle.
- o_dbg_rsp_valid  out  1  o_dbg_rdata is valid.
- o_dbg_rdata  out  32  debug read data.
- o_rf_reset  out  1  synchronous clear to the register file.
- o_rf_we  out  1  register-file write enable.
- o_rf_waddr  out  5  register-file write address.
- o_rf_wdata  out  32  register-file write data.
- o_rf_raddr1  out  5  register-file read address 1.
- o_rf_raddr2  out  5  register-file read address 2.
- i_rf_rdata1  in  32  register-file registered read data 1.
- i_rf_rdata2  in  32  register-file registered read data 2.

Behaviour:
- **States**
  - S_INIT: entered asynchronously while i_reset_n=0.
    - o_rf_reset=1; all readies=0; o_rf_we=0.
    - o_dec_rsp_valid=0, o_dbg_rsp_valid=0.
    - Debug wait counter=0; init counter=0.
  - After reset release, the block stays in S_INIT for INIT_CYCLES rising edges, then moves to S_RUN with o_rf_reset=0.
  - S_RUN: arbitration active. There is no exit except reset.
- **Handshakes**
  - A transfer occurs when valid&ready in the same cycle.
  - Readies are combinational from valids and state.
  - Requesters must hold their request stable until accepted.
- **Slot priority in S_RUN**
  - Order: promoted debug > writeback > decode > debug.
  - One slot per cycle.
- **x0 writes**
  - A write to address 0 (writeback or debug) is accepted without using the slot: ready=1 and o_rf_we=0 for it.
  - The slot remains free for the next requester in priority order that same cycle.
- **Write grant**
  - o_rf_we=1; o_rf_waddr and o_rf_wdata are taken from the granted requester.
- **No write granted**
  - o_rf_we=0.
  - o_rf_raddr1/2 = i_dec_rs1/rs2 if decode is granted, else i_dbg_addr/i_dbg_addr if a debug read is granted, else i_dec_rs1/rs2.
  - Ungranted reads are harmless and produce no response.
- **Responses**
  - Read issued in cycle N → rsp_valid=1 for exactly cycle N+1 on the issuing requester only.
  - Response data is a combinational passthrough:
    - o_rs1_data=i_rf_rdata1, o_rs2_data=i_rf_rdata2.
    - o_dbg_rdata=i_rf_rdata1.
  - rsp_valid flags are registered.
- **Ordering**
  - A write granted in cycle N is visible to a read granted in cycle N+1 or later. No bypass.
- **Starvation control**
  - The debug wait counter increments each S_RUN cycle in which i_dbg_valid=1 and o_dbg_ready=0. It saturates at DBG_MAX_WAIT.
  - At DBG_MAX_WAIT, debug is promoted for the next cycle.
  - The counter clears on any debug acceptance.
  - Writeback stalls for that one cycle.
- **Reset mid-operation**
  - An in-flight response is discarded: rsp_valid drops immediately and asynchronously.
  - An ungranted request is not retained.

Test Plan:
- **Reset/init:** hold i_reset_n=0 for 3 cycles, release → o_rf_reset=1 for exactly 2 cycles after release; all readies 0 until S_RUN.
- **Write-then-read:** wb writes x5=0xDEADBEEF (cycle N), decode reads rs1=5, rs2=0 (cycle N+1) → o_dec_rsp_valid at N+2 with o_rs1_data=0xDEADBEEF and o_rs2_data=0.
- **Contention:** wb and decode both valid in the same cycle → o_wb_ready=1, o_dec_ready=0; decode granted the next cycle; one response pulse only.
- **x0 write:** wb writes x0=0x1234 while decode is valid → o_wb_ready=1, o_rf_we=0, o_dec_ready=1 in the same cycle; a later read of x0 returns 0.
- **Debug starvation:** wb and debug read held valid continuously, DBG_MAX_WAIT=8 → debug accepted on the 9th cycle; wb stalls that cycle; o_dbg_rsp_valid the cycle after.
- **Reset mid-read:** assert i_reset_n=0 in the cycle after a decode grant → o_dec_rsp_valid=0 immediately; the block re-enters S_INIT.

Source files
------------

// File: rtl/regfile_access_arbiter.sv
// Shares one single-access 32x32 register file between writeback, decode and debug.
// Grants one slot per cycle, drops x0 writes, routes read responses and sequences RF clearing.
module regfile_access_arbiter #(
  parameter int INIT_CYCLES  = 2,
  parameter int DBG_MAX_WAIT = 8
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_wb_valid,
  input  logic [4:0]  i_wb_rd,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_ready,
  input  logic        i_dec_valid,
  input  logic [4:0]  i_dec_rs1,
  input  logic [4:0]  i_dec_rs2,
  output logic        o_dec_ready,
  output logic        o_dec_rsp_valid,
  output logic [31:0] o_rs1_data,
  output logic [31:0] o_rs2_data,
  input  logic        i_dbg_valid,
  input  logic        i_dbg_we,
  input  logic [4:0]  i_dbg_addr,
  input  logic [31:0] i_dbg_wdata,
  output logic        o_dbg_ready,
  output logic        o_dbg_rsp_valid,
  output logic [31:0] o_dbg_rdata,
  output logic        o_rf_reset,
  output logic        o_rf_we,
  output logic [4:0]  o_rf_waddr,
  output logic [31:0] o_rf_wdata,
  output logic [4:0]  o_rf_raddr1,
  output logic [4:0]  o_rf_raddr2,
  input  logic [31:0] i_rf_rdata1,
  input  logic [31:0] i_rf_rdata2
);

  localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int WW = $clog2(DBG_MAX_WAIT + 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(DBG_MAX_WAIT);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t        state_r, state_s;
  logic [IW-1:0] init_cnt_r, init_cnt_s;
  logic [WW-1:0] dbg_wait_r;
  logic          dec_rsp_r, dbg_rsp_r;

  logic run_s;
  logic wb_x0_s, dbg_x0_s, wb_need_s, dbg_need_s, promote_s;
  logic gnt_wb_s, gnt_dec_s, gnt_dbg_s;

  // State and init-counter registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r    <= S_INIT;
      init_cnt_r <= {IW{1'b0}};
    end else begin
      state_r    <= state_s;
      init_cnt_r <= init_cnt_s;
    end
  end

  // Next state: hold S_INIT for INIT_CYCLES edges after release, then run forever
  always_comb begin
    state_s    = state_r;
    init_cnt_s = init_cnt_r;
    case (state_r)
      S_INIT: begin
        if (init_cnt_r == INIT_LAST) begin
          state_s    = S_RUN;
          init_cnt_s = {IW{1'b0}};
        end else begin
          init_cnt_s = init_cnt_r + IW'(1);
        end
      end
      S_RUN:   state_s = S_RUN;
      default: state_s = S_INIT;
    endcase
  end

  assign run_s      = (state_r == S_RUN);
  assign o_rf_reset = (state_r == S_INIT);

  // Writes to x0 are acknowledged without consuming the register-file slot
  assign wb_x0_s    = i_wb_valid & (i_wb_rd == 5'd0);
  assign dbg_x0_s   = i_dbg_valid & i_dbg_we & (i_dbg_addr == 5'd0);
  assign wb_need_s  = i_wb_valid & ~wb_x0_s;
  assign dbg_need_s = i_dbg_valid & ~dbg_x0_s;
  assign promote_s  = (dbg_wait_r == WAIT_MAX);

  // Slot arbitration: promoted debug > writeback > decode > debug
  always_comb begin
    gnt_wb_s  = 1'b0;
    gnt_dec_s = 1'b0;
    gnt_dbg_s = 1'b0;
    if (!run_s) begin
      gnt_dbg_s = 1'b0;
    end else if (promote_s && dbg_need_s) begin
      gnt_dbg_s = 1'b1;
    end else if (wb_need_s) begin
      gnt_wb_s = 1'b1;
    end else if (i_dec_valid) begin
      gnt_dec_s = 1'b1;
    end else if (dbg_need_s) begin
      gnt_dbg_s = 1'b1;
    end else begin
      gnt_dbg_s = 1'b0;
    end
  end

  assign o_wb_ready  = run_s & (wb_x0_s | gnt_wb_s);
  assign o_dec_ready = gnt_dec_s;
  assign o_dbg_ready = run_s & (dbg_x0_s | gnt_dbg_s);

  // Register-file command mux; read ports idle on decode addresses
  always_comb begin
    o_rf_we     = 1'b0;
    o_rf_waddr  = 5'd0;
    o_rf_wdata  = 32'd0;
    o_rf_raddr1 = i_dec_rs1;
    o_rf_raddr2 = i_dec_rs2;
    if (gnt_wb_s) begin
      o_rf_we    = 1'b1;
      o_rf_waddr = i_wb_rd;
      o_rf_wdata = i_wb_data;
    end else if (gnt_dbg_s && i_dbg_we) begin
      o_rf_we    = 1'b1;
      o_rf_waddr = i_dbg_addr;
      o_rf_wdata = i_dbg_wdata;
    end else if (gnt_dbg_s) begin
      o_rf_raddr1 = i_dbg_addr;
      o_rf_raddr2 = i_dbg_addr;
    end else begin
      o_rf_raddr1 = i_dec_rs1;
      o_rf_raddr2 = i_dec_rs2;
    end
  end

  // Debug starvation counter: saturating count of denied debug cycles
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      dbg_wait_r <= {WW{1'b0}};
    end else if (!run_s || o_dbg_ready) begin
      dbg_wait_r <= {WW{1'b0}};
    end else if (i_dbg_valid && (dbg_wait_r != WAIT_MAX)) begin
      dbg_wait_r <= dbg_wait_r + WW'(1);
    end else begin
      dbg_wait_r <= dbg_wait_r;
    end
  end

  // Response flags follow the read grant by one cycle
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      dec_rsp_r <= 1'b0;
      dbg_rsp_r <= 1'b0;
    end else begin
      dec_rsp_r <= gnt_dec_s;
      dbg_rsp_r <= gnt_dbg_s & ~i_dbg_we;
    end
  end

  assign o_dec_rsp_valid = dec_rsp_r;
  assign o_dbg_rsp_valid = dbg_rsp_r;
  assign o_rs1_data      = i_rf_rdata1;
  assign o_rs2_data      = i_rf_rdata2;
  assign o_dbg_rdata     = i_rf_rdata1;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Testbench for regfile_access_arbiter: directed scenarios plus randomized traffic
// checked against a golden register array and priority-rule reference model.
module tb_regfile_access_arbiter;

  localparam int INIT_CYCLES  = 2;
  localparam int DBG_MAX_WAIT = 8;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_wb_valid;
  logic [4:0]  i_wb_rd;
  logic [31:0] i_wb_data;
  logic        o_wb_ready;
  logic        i_dec_valid;
  logic [4:0]  i_dec_rs1;
  logic [4:0]  i_dec_rs2;
  logic        o_dec_ready;
  logic        o_dec_rsp_valid;
  logic [31:0] o_rs1_data;
  logic [31:0] o_rs2_data;
  logic        i_dbg_valid;
  logic        i_dbg_we;
  logic [4:0]  i_dbg_addr;
  logic [31:0] i_dbg_wdata;
  logic        o_dbg_ready;
  logic        o_dbg_rsp_valid;
  logic [31:0] o_dbg_rdata;
  logic        o_rf_reset;
  logic        o_rf_we;
  logic [4:0]  o_rf_waddr;
  logic [31:0] o_rf_wdata;
  logic [4:0]  o_rf_raddr1;
  logic [4:0]  o_rf_raddr2;
  logic [31:0] i_rf_rdata1;
  logic [31:0] i_rf_rdata2;

  int checks = 0;
  int errors = 0;

  regfile_access_arbiter #(
    .INIT_CYCLES (INIT_CYCLES),
    .DBG_MAX_WAIT(DBG_MAX_WAIT)
  ) dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_wb_valid     (i_wb_valid),
    .i_wb_rd        (i_wb_rd),
    .i_wb_data      (i_wb_data),
    .o_wb_ready     (o_wb_ready),
    .i_dec_valid    (i_dec_valid),
    .i_dec_rs1      (i_dec_rs1),
    .i_dec_rs2      (i_dec_rs2),
    .o_dec_ready    (o_dec_ready),
    .o_dec_rsp_valid(o_dec_rsp_valid),
    .o_rs1_data     (o_rs1_data),
    .o_rs2_data     (o_rs2_data),
    .i_dbg_valid    (i_dbg_valid),
    .i_dbg_we       (i_dbg_we),
    .i_dbg_addr     (i_dbg_addr),
    .i_dbg_wdata    (i_dbg_wdata),
    .o_dbg_ready    (o_dbg_ready),
    .o_dbg_rsp_valid(o_dbg_rsp_valid),
    .o_dbg_rdata    (o_dbg_rdata),
    .o_rf_reset     (o_rf_reset),
    .o_rf_we        (o_rf_we),
    .o_rf_waddr     (o_rf_waddr),
    .o_rf_wdata     (o_rf_wdata),
    .o_rf_raddr1    (o_rf_raddr1),
    .o_rf_raddr2    (o_rf_raddr2),
    .i_rf_rdata1    (i_rf_rdata1),
    .i_rf_rdata2    (i_rf_rdata2)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Single-access register file: one write or one registered two-port read per clock
  logic [31:0] rf_mem [32];
  always @(posedge i_clk) begin
    if (o_rf_reset) begin
      for (int k = 0; k < 32; k++) rf_mem[k] <= 32'h0;
    end else if (o_rf_we) begin
      rf_mem[o_rf_waddr] <= o_rf_wdata;
    end else begin
      i_rf_rdata1 <= rf_mem[o_rf_raddr1];
      i_rf_rdata2 <= rf_mem[o_rf_raddr2];
    end
  end

  task automatic idle_inputs();
    i_wb_valid  = 1'b0; i_wb_rd  = 5'd0; i_wb_data   = 32'h0;
    i_dec_valid = 1'b0; i_dec_rs1 = 5'd0; i_dec_rs2  = 5'd0;
    i_dbg_valid = 1'b0; i_dbg_we = 1'b0; i_dbg_addr  = 5'd0; i_dbg_wdata = 32'h0;
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    idle_inputs();
    i_wb_valid = 1'b1; i_wb_rd = 5'd9; i_dbg_valid = 1'b1; i_dec_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      checks++; if (o_rf_reset !== 1'b1) begin errors++; $display("FAIL reset_rf_reset: got %b want 1", o_rf_reset); end
      checks++; if ({o_wb_ready, o_dec_ready, o_dbg_ready} !== 3'b000) begin errors++; $display("FAIL reset_readies: got %b want 000", {o_wb_ready, o_dec_ready, o_dbg_ready}); end
      checks++; if ({o_dec_rsp_valid, o_dbg_rsp_valid} !== 2'b00) begin errors++; $display("FAIL reset_rsp: got %b want 00", {o_dec_rsp_valid, o_dbg_rsp_valid}); end
    end
    next_cycle();
    i_reset_n = 1'b1; i_wb_valid = 1'b0; i_dbg_valid = 1'b0;
    for (int c = 0; c < INIT_CYCLES; c++) begin
      @(negedge i_clk);
      checks++; if (o_rf_reset !== 1'b1) begin errors++; $display("FAIL init_rf_reset c%0d: got %b want 1", c, o_rf_reset); end
      checks++; if (o_dec_ready !== 1'b0) begin errors++; $display("FAIL init_dec_ready c%0d: got %b want 0", c, o_dec_ready); end
      next_cycle();
    end
    @(negedge i_clk);
    checks++; if (o_rf_reset !== 1'b0) begin errors++; $display("FAIL run_rf_reset: got %b want 0", o_rf_reset); end
    checks++; if (o_dec_ready !== 1'b1) begin errors++; $display("FAIL run_dec_ready: got %b want 1", o_dec_ready); end
    next_cycle();
    i_dec_valid = 1'b0;
    @(negedge i_clk);
    checks++; if (o_dec_rsp_valid !== 1'b1) begin errors++; $display("FAIL init_rsp_valid: got %b want 1", o_dec_rsp_valid); end
    checks++; if (o_rs1_data !== 32'h0) begin errors++; $display("FAIL init_cleared: got %h want 0", o_rs1_data); end
    next_cycle();
  endtask

  task automatic test_write_then_read();
    i_wb_valid = 1'b1; i_wb_rd = 5'd5; i_wb_data = 32'hDEADBEEF;
    @(negedge i_clk);
    checks++; if (o_wb_ready !== 1'b1) begin errors++; $display("FAIL wtr_wb_ready: got %b want 1", o_wb_ready); end
    checks++; if ({o_rf_we, o_rf_waddr, o_rf_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin errors++; $display("FAIL wtr_rf_write: got %b/%0d/%h want 1/5/deadbeef", o_rf_we, o_rf_waddr, o_rf_wdata); end
    next_cycle();
    i_wb_valid = 1'b0; i_dec_valid = 1'b1; i_dec_rs1 = 5'd5; i_dec_rs2 = 5'd0;
    @(negedge i_clk);
    checks++; if (o_dec_ready !== 1'b1) begin errors++; $display("FAIL wtr_dec_ready: got %b want 1", o_dec_ready); end
    checks++; if ({o_rf_raddr1, o_rf_raddr2} !== {5'd5, 5'd0}) begin errors++; $display("FAIL wtr_raddr: got %0d/%0d want 5/0", o_rf_raddr1, o_rf_raddr2); end
    next_cycle();
    i_dec_valid = 1'b0;
    @(negedge i_clk);
    checks++; if (o_dec_rsp_valid !== 1'b1) begin errors++; $display("FAIL wtr_rsp_valid: got %b want 1", o_dec_rsp_valid); end
    checks++; if (o_rs1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wtr_rs1: got %h want deadbeef", o_rs1_data); end
    checks++; if (o_rs2_data !== 32'h0) begin errors++; $display("FAIL wtr_rs2: got %h want 0", o_rs2_data); end
    checks++; if (o_dbg_rsp_valid !== 1'b0) begin errors++; $display("FAIL wtr_dbg_rsp: got %b want 0", o_dbg_rsp_valid); end
    next_cycle();
    @(negedge i_clk);
    checks++; if (o_dec_rsp_valid !== 1'b0) begin errors++; $display("FAIL wtr_rsp_pulse: got %b want 0", o_dec_rsp_valid); end
    next_cycle();
  endtask

  task automatic test_contention();
    i_wb_valid = 1'b1; i_wb_rd = 5'd6; i_wb_data = 32'h11111111;
    i_dec_valid = 1'b1; i_dec_rs1 = 5'd6; i_dec_rs2 = 5'd5;
    @(negedge i_clk);
    checks++; if ({o_wb_ready, o_dec_ready} !== 2'b10) begin errors++; $display("FAIL cont_first: got wb=%b dec=%b want 1/0", o_wb_ready, o_dec_ready); end
    next_cycle();
    i_wb_valid = 1'b0;
    @(negedge i_clk);
    checks++; if (o_dec_ready !== 1'b1) begin errors++; $display("FAIL cont_dec_ready: got %b want 1", o_dec_ready); end
    checks++; if (o_dec_rsp_valid !== 1'b0) begin errors++; $display("FAIL cont_early_rsp: got %b want 0", o_dec_rsp_valid); end
    next_cycle();
    i_dec_valid = 1'b0;
    @(negedge i_clk);
    checks++; if (o_dec_rsp_valid !== 1'b1) begin errors++; $display("FAIL cont_rsp: got %b want 1", o_dec_rsp_valid); end
    checks++; if ({o_rs1_data, o_rs2_data} !== {32'h11111111, 32'hDEADBEEF}) begin errors++; $display("FAIL cont_data: got %h/%h want 11111111/deadbeef", o_rs1_data, o_rs2_data); end
    next_cycle();
    @(negedge i_clk);
    checks++; if (o_dec_rsp_valid !== 1'b0) begin errors++; $display("FAIL cont_one_pulse: got %b want 0", o_dec_rsp_valid); end
    next_cycle();
  endtask

  task automatic test_x0_write();
    i_wb_valid = 1'b1; i_wb_rd = 5'd0; i_wb_data = 32'h00001234;
    i_dec_valid = 1'b1; i_dec_rs1 = 5'd0; i_dec_rs2 = 5'd5;
    @(negedge i_clk);
    checks++; if ({o_wb_ready, o_rf_we, o_dec_ready} !== 3'b101) begin errors++; $display("FAIL x0_same_cycle: got wb=%b we=%b dec=%b want 1/0/1", o_wb_ready, o_rf_we, o_dec_ready); end
    next_cycle();
    idle_inputs();
    @(negedge i_clk);
    checks++; if (o_dec_rsp_valid !== 1'b1) begin errors++; $display("FAIL x0_rsp: got %b want 1", o_dec_rsp_valid); end
    checks++; if ({o_rs1_data, o_rs2_data} !== {32'h0, 32'hDEADBEEF}) begin errors++; $display("FAIL x0_data: got %h/%h want 0/deadbeef", o_rs1_data, o_rs2_data); end
    next_cycle();
  endtask

  task automatic test_dbg_starvation();
    i_wb_valid = 1'b1; i_wb_rd = 5'd7; i_wb_data = 32'hA5A5A5A5;
    i_dbg_valid = 1'b1; i_dbg_we = 1'b0; i_dbg_addr = 5'd5;
    for (int c = 1; c <= DBG_MAX_WAIT; c++) begin
      @(negedge i_clk);
      checks++; if ({o_wb_ready, o_dbg_ready} !== 2'b10) begin errors++; $display("FAIL starve_c%0d: got wb=%b dbg=%b want 1/0", c, o_wb_ready, o_dbg_ready); end
      next_cycle();
    end
    @(negedge i_clk);
    checks++; if ({o_wb_ready, o_dbg_ready} !== 2'b01) begin errors++; $display("FAIL starve_promote: got wb=%b dbg=%b want 0/1", o_wb_ready, o_dbg_ready); end
    checks++; if ({o_rf_we, o_rf_raddr1} !== {1'b0, 5'd5}) begin errors++; $display("FAIL starve_raddr: got we=%b addr=%0d want 0/5", o_rf_we, o_rf_raddr1); end
    next_cycle();
    i_dbg_valid = 1'b0;
    @(negedge i_clk);
    checks++; if (o_dbg_rsp_valid !== 1'b1) begin errors++; $display("FAIL starve_rsp: got %b want 1", o_dbg_rsp_valid); end
    checks++; if (o_dbg_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL starve_rdata: got %h want deadbeef", o_dbg_rdata); end
    checks++; if ({o_wb_ready, o_dec_rsp_valid} !== 2'b10) begin errors++; $display("FAIL starve_after: got wb=%b decrsp=%b want 1/0", o_wb_ready, o_dec_rsp_valid); end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    i_dec_valid = 1'b1; i_dec_rs1 = 5'd5; i_dec_rs2 = 5'd6;
    @(negedge i_clk);
    checks++; if (o_dec_ready !== 1'b1) begin errors++; $display("FAIL mid_dec_ready: got %b want 1", o_dec_ready); end
    next_cycle();
    i_dec_valid = 1'b0;
    checks++; if (o_dec_rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_rsp_before: got %b want 1", o_dec_rsp_valid); end
    i_reset_n = 1'b0;
    #1;
    checks++; if (o_dec_rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_dropped: got %b want 0", o_dec_rsp_valid); end
    checks++; if (o_rf_reset !== 1'b1) begin errors++; $display("FAIL mid_reinit: got %b want 1", o_rf_reset); end
    repeat (2) next_cycle();
    i_reset_n = 1'b1;
    repeat (INIT_CYCLES) next_cycle();
    @(negedge i_clk);
    checks++; if (o_rf_reset !== 1'b0) begin errors++; $display("FAIL mid_rerun: got %b want 0", o_rf_reset); end
    next_cycle();
  endtask

  // Random traffic against a golden register array and the documented priority rules
  task automatic test_random(input int ncyc);
    logic [31:0] gold [32];
    int          m_wait, owner;
    bit          wb_p, dec_p, dbg_p, x_wb, x_dec, x_dbg;
    bit          wb_free, dbg_free, wb_need, dbg_need;
    bit          e_dec_rsp, e_dbg_rsp;
    logic [31:0] e_rs1, e_rs2, e_dbg;
    for (int k = 0; k < 32; k++) gold[k] = 32'h0;
    m_wait = 0; wb_p = 1'b0; dec_p = 1'b0; dbg_p = 1'b0;
    e_dec_rsp = 1'b0; e_dbg_rsp = 1'b0; e_rs1 = 32'h0; e_rs2 = 32'h0; e_dbg = 32'h0;
    for (int c = 0; c < ncyc; c++) begin
      if (!wb_p) begin
        i_wb_valid = ($urandom_range(0, 1) == 1); i_wb_rd = 5'($urandom_range(0, 7)); i_wb_data = $urandom;
      end
      if (!dec_p) begin
        i_dec_valid = ($urandom_range(0, 1) == 1); i_dec_rs1 = 5'($urandom_range(0, 7)); i_dec_rs2 = 5'($urandom_range(0, 7));
      end
      if (!dbg_p) begin
        i_dbg_valid = ($urandom_range(0, 3) == 0); i_dbg_we = ($urandom_range(0, 1) == 1);
        i_dbg_addr = 5'($urandom_range(0, 7)); i_dbg_wdata = $urandom;
      end
      wb_p = i_wb_valid; dec_p = i_dec_valid; dbg_p = i_dbg_valid;
      wb_free  = i_wb_valid && (i_wb_rd == 5'd0);
      dbg_free = i_dbg_valid && i_dbg_we && (i_dbg_addr == 5'd0);
      wb_need  = i_wb_valid && !wb_free;
      dbg_need = i_dbg_valid && !dbg_free;
      // owner: 0 none, 1 writeback, 2 decode, 3 debug
      owner = 0;
      if (dbg_need && m_wait >= DBG_MAX_WAIT) owner = 3;
      else if (wb_need) owner = 1;
      else if (i_dec_valid) owner = 2;
      else if (dbg_need) owner = 3;
      x_wb = wb_free || owner == 1; x_dec = (owner == 2); x_dbg = dbg_free || owner == 3;
      @(negedge i_clk);
      checks++; if ({o_wb_ready, o_dec_ready, o_dbg_ready} !== {x_wb, x_dec, x_dbg}) begin errors++; $display("FAIL rnd_ready c%0d: got %b want %b", c, {o_wb_ready, o_dec_ready, o_dbg_ready}, {x_wb, x_dec, x_dbg}); end
      checks++; if (o_rf_we !== (owner == 1 || (owner == 3 && i_dbg_we))) begin errors++; $display("FAIL rnd_we c%0d: got %b", c, o_rf_we); end
      if (owner == 1) begin
        checks++; if ({o_rf_waddr, o_rf_wdata} !== {i_wb_rd, i_wb_data}) begin errors++; $display("FAIL rnd_wb_write c%0d: got %0d/%h want %0d/%h", c, o_rf_waddr, o_rf_wdata, i_wb_rd, i_wb_data); end
      end
      if (owner == 3 && i_dbg_we) begin
        checks++; if ({o_rf_waddr, o_rf_wdata} !== {i_dbg_addr, i_dbg_wdata}) begin errors++; $display("FAIL rnd_dbg_write c%0d: got %0d/%h want %0d/%h", c, o_rf_waddr, o_rf_wdata, i_dbg_addr, i_dbg_wdata); end
      end
      checks++; if (o_dec_rsp_valid !== e_dec_rsp) begin errors++; $display("FAIL rnd_dec_rsp c%0d: got %b want %b", c, o_dec_rsp_valid, e_dec_rsp); end
      if (e_dec_rsp) begin
        checks++; if ({o_rs1_data, o_rs2_data} !== {e_rs1, e_rs2}) begin errors++; $display("FAIL rnd_dec_data c%0d: got %h/%h want %h/%h", c, o_rs1_data, o_rs2_data, e_rs1, e_rs2); end
      end
      checks++; if (o_dbg_rsp_valid !== e_dbg_rsp) begin errors++; $display("FAIL rnd_dbg_rsp c%0d: got %b want %b", c, o_dbg_rsp_valid, e_dbg_rsp); end
      if (e_dbg_rsp) begin
        checks++; if (o_dbg_rdata !== e_dbg) begin errors++; $display("FAIL rnd_dbg_data c%0d: got %h want %h", c, o_dbg_rdata, e_dbg); end
      end
      e_dec_rsp = (owner == 2); e_rs1 = gold[i_dec_rs1]; e_rs2 = gold[i_dec_rs2];
      e_dbg_rsp = (owner == 3) && !i_dbg_we; e_dbg = gold[i_dbg_addr];
      if (owner == 1) gold[i_wb_rd] = i_wb_data;
      if (owner == 3 && i_dbg_we) gold[i_dbg_addr] = i_dbg_wdata;
      if (x_dbg) m_wait = 0;
      else if (i_dbg_valid && m_wait < DBG_MAX_WAIT) m_wait++;
      if (x_wb) wb_p = 1'b0;
      if (x_dec) dec_p = 1'b0;
      if (x_dbg) dbg_p = 1'b0;
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    idle_inputs();
    i_reset_n = 1'b0;
    test_reset();
    test_write_then_read();
    test_contention();
    test_x0_write();
    test_dbg_starvation();
    test_reset_mid_read();
    test_random(600);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
